vedic_mult_pipe: RTL
====================

# vedic_mult_pipe

Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with valid/ready handshakes on input and output. It generalises the team's fixed 8-bit combinational Vedic multiplier to any power-of-two operand width. It also adds a three-stage pipeline with full-throughput streaming and output backpressure. It sits in the datapath between an operand source and a product consumer, both of which use valid/ready flow control.

## Interface

- WIDTH, 8, operand width in bits; power of two, 4..32
- OUT_W, 2*WIDTH, product width (derived; not overridable)
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product presented
- out_ready  input  1  consumer accepts product this cycle
- p  output  OUT_W  product a*b
- is_signed  input  1  present only with VEDIC_SIGNED_EN; qualifies a/b as two's complement

## Operation

- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline stages:
  - S1 registers the operands and a valid bit.
  - S2 computes the four WIDTH/2 × WIDTH/2 partial products (aH·bH, aH·bL, aL·bH, aL·bL) with a recursive Vedic tree of 2×2 cells, then registers them.
  - S3 performs the shifted Vedic sum (aL·bL + ((aH·bL + aL·bH) << WIDTH/2) + (aH·bH << WIDTH)) into OUT_W bits and registers it as p/out_valid.
- Stall control:
  - stall = out_valid && !out_ready.
  - Every stage advances only when !stall.
  - in_ready = !stall, combinational from out_valid/out_ready.
- Behaviour during stall:
  - All stage registers, including p, hold.
  - Bubbles are not compressed.
- Arithmetic:
  - The unsigned product is exact; no truncation, since OUT_W = 2*WIDTH.
  - The internal 3-term sum is carried at OUT_W+1 bits; the top bit is provably 0 and is dropped.
- Idle behaviour: with no input transfer, a bubble (valid=0) propagates, and p is don't-care while out_valid=0.
- Reset:
  - When rst_n=0 at a clock edge, all valid bits and p clear to 0.
  - In-flight operands are discarded and never emerge.
  - While rst_n=0, in_ready follows !stall. Because out_valid is 0 after the first reset edge, in_ready reads 1, but inputs presented during reset are dropped.

## Timing

- Reset values: out_valid=0, p=0. in_ready=1 after the reset edge, since out_valid=0.
- Latency: a product appears on p/out_valid exactly 3 clk edges after its input transfer, provided no stall occurs.
- Throughput: one product per cycle when out_ready is held at 1.
- Each stall cycle adds exactly one cycle of latency to every in-flight item.
- Simultaneous stall release and new input:
  - in_ready=1 in any cycle where out_ready=1, so the pipeline accepts a new pair in the same cycle the output is consumed.
- Data hold: p and out_valid remain stable while out_valid && !out_ready. This follows the AXI-style rule that data does not change until accepted.

## Configuration

- VEDIC_SIGNED_EN: when defined, adds the is_signed port and a signed path.
  - S1 captures |a|, |b| (two's-complement negate when the MSB is set and is_signed=1), plus a registered sign flag equal to sign(a) XOR sign(b).
  - S3 negates the OUT_W magnitude when the flag is set.
  - Latency is unchanged.
  - Edge case: -2^(WIDTH-1) × -2^(WIDTH-1) yields 2^(2*WIDTH-2), which is exact in OUT_W bits.
  - With is_signed=0, behaviour is identical to the unsigned build.
- Without the macro, the is_signed port is absent and the operands are always unsigned.

## Test plan

- WIDTH=8, out_ready=1, one transfer per cycle with a=b=0,1,3,7,15,31,63,127,255 -> p=0,1,9,49,225,961,3969,16129,65025 (0xFE01), each 3 cycles after input, back to back.
- WIDTH=8, send a=200,b=100 then a=13,b=11, holding out_ready=0 for 4 cycles after the first out_valid -> p=20000 held stable, in_ready=0 during the hold; on release, 20000 and then 143 are delivered in consecutive cycles.
- WIDTH=16, a=0xFFFF, b=0xFFFF -> p=0xFFFE0001. WIDTH=4, a=0xF, b=0xF -> p=0xE1.
- Stream 3 pairs, assert rst_n=0 for one cycle after the second input transfer -> out_valid=0 and p=0 after the reset edge; none of the three products ever appears; the first post-reset input produces the next valid output.
- VEDIC_SIGNED_EN, WIDTH=8, is_signed=1:
  - -1×127 -> p=0xFF81
  - -128×-128 -> p=0x4000
  - -128×127 -> p=0xC080
  - With is_signed=0, 0xFF×0x7F -> p=0x7E81.
- Random streaming, 10k pairs with random in_valid/out_ready at WIDTH 4, 8, 16, 32 -> every product matches a reference a*b in order, with no drops or duplicates.

Source files
------------

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage pipelined Urdhva-Tiryagbhyam multiplier, valid/ready.
// Define VEDIC_SIGNED_EN to add the is_signed port and sign-magnitude path.
module vedic_cell #(
  parameter int N = 2
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  if (N == 2) begin : g_leaf
    logic pp00, pp01, pp10, pp11, c1;
    assign pp00 = a[0] & b[0];
    assign pp01 = a[0] & b[1];
    assign pp10 = a[1] & b[0];
    assign pp11 = a[1] & b[1];
    assign c1   = pp10 & pp01;
    assign p    = {pp11 & c1, pp11 ^ c1, pp10 ^ pp01, pp00};
  end else begin : g_tree
    localparam int H = N / 2;
    typedef logic [2*N-1:0] acc_t;
    logic [N-1:0] hh, hl, lh, ll;
    vedic_cell #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));
    vedic_cell #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_cell #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
    vedic_cell #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    assign p = acc_t'(ll)
             + (acc_t'(hl) << H)
             + (acc_t'(lh) << H)
             + (acc_t'(hh) << N);
  end
endmodule

module vedic_mult_pipe #(
  parameter  int WIDTH = 8,
  localparam int OUT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef VEDIC_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p
);
  localparam int H  = WIDTH / 2;
  localparam int SW = OUT_W + 1;
  typedef logic [SW-1:0] sum_t;

  logic             stall;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic             sg_in, sg1_q, sg1_d, sg2_q, sg2_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic [WIDTH-1:0] pp_hh, pp_hl, pp_lh, pp_ll;
  logic [WIDTH-1:0] hh_q, hh_d, hl_q, hl_d;
  logic [WIDTH-1:0] lh_q, lh_d, ll_q, ll_d;
  logic [OUT_W-1:0] p_q, p_d, mag;
  sum_t             sum;
  logic             unused_msb;

  assign stall     = v3_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v3_q;
  assign p         = p_q;

`ifdef VEDIC_SIGNED_EN
  logic a_neg, b_neg;
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign sg_in = a_neg ^ b_neg;
`else
  assign a_mag = a;
  assign b_mag = b;
  assign sg_in = 1'b0;
`endif

  vedic_cell #(.N(H)) u_hh (
    .a(a1_q[WIDTH-1:H]), .b(b1_q[WIDTH-1:H]), .p(pp_hh));
  vedic_cell #(.N(H)) u_hl (
    .a(a1_q[WIDTH-1:H]), .b(b1_q[H-1:0]), .p(pp_hl));
  vedic_cell #(.N(H)) u_lh (
    .a(a1_q[H-1:0]), .b(b1_q[WIDTH-1:H]), .p(pp_lh));
  vedic_cell #(.N(H)) u_ll (
    .a(a1_q[H-1:0]), .b(b1_q[H-1:0]), .p(pp_ll));

  // top carry of the 3-term sum is always zero for an exact 2*WIDTH product
  assign sum = sum_t'(ll_q)
             + (sum_t'(hl_q) << H)
             + (sum_t'(lh_q) << H)
             + (sum_t'(hh_q) << WIDTH);
  assign mag        = sum[OUT_W-1:0];
  assign unused_msb = sum[SW-1];

  always_comb begin
    v1_d  = v1_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    sg1_d = sg1_q;
    v2_d  = v2_q;
    hh_d  = hh_q;
    hl_d  = hl_q;
    lh_d  = lh_q;
    ll_d  = ll_q;
    sg2_d = sg2_q;
    v3_d  = v3_q;
    p_d   = p_q;
    if (!stall) begin
      v1_d  = in_valid;
      a1_d  = a_mag;
      b1_d  = b_mag;
      sg1_d = sg_in;
      v2_d  = v1_q;
      hh_d  = pp_hh;
      hl_d  = pp_hl;
      lh_d  = pp_lh;
      ll_d  = pp_ll;
      sg2_d = sg1_q;
      v3_d  = v2_q;
      p_d   = sg2_q ? -mag : mag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      sg1_q <= 1'b0;
      v2_q  <= 1'b0;
      hh_q  <= '0;
      hl_q  <= '0;
      lh_q  <= '0;
      ll_q  <= '0;
      sg2_q <= 1'b0;
      v3_q  <= 1'b0;
      p_q   <= '0;
    end else begin
      v1_q  <= v1_d;
      a1_q  <= a1_d;
      b1_q  <= b1_d;
      sg1_q <= sg1_d;
      v2_q  <= v2_d;
      hh_q  <= hh_d;
      hl_q  <= hl_d;
      lh_q  <= lh_d;
      ll_q  <= ll_d;
      sg2_q <= sg2_d;
      v3_q  <= v3_d;
      p_q   <= p_d;
    end
  end
endmodule
